pcnt_usadd: RTL and testbench
=============================

PCNT_USADD -- requirements
Module: pcnt_usadd

Interface
REQ-001 SHALL have parameter NUM_IN, default 15, meaning the number of unary input bitstreams (legal range 2..64).
REQ-002 SHALL have derived localparam CNTW = clog2(NUM_IN+1), meaning the popcount width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_bits is sampled this cycle.
REQ-006 SHALL have port in_bits  input  NUM_IN  meaning one bit from each input stream.
REQ-007 SHALL have port clear  input  1  meaning synchronous accumulator clear and pipeline flush.
REQ-008 SHALL have port out_valid  output  1  meaning out_bit and acc are valid.
REQ-009 SHALL have port out_bit  output  1  meaning the scaled-add output stream bit (sum/NUM_IN).
REQ-010 SHALL have port cnt  output  CNTW  meaning the registered stage-1 popcount.
REQ-011 SHALL have port acc  output  CNTW  meaning the accumulator residue, always < NUM_IN.

Function
REQ-012 Stage 1 SHALL register cnt = popcount(in_bits) and set the internal flag s1_valid = 1 on a cycle with in_valid=1; with in_valid=0, s1_valid=0 and cnt holds.
REQ-013 Stage 2 SHALL form sum = acc + cnt at CNTW+1 bits when s1_valid=1, with no overflow possible.
REQ-014 If sum >= NUM_IN, stage 2 SHALL register out_bit=1 and acc=sum-NUM_IN; otherwise out_bit=0 and acc=sum.
REQ-015 out_valid SHALL equal s1_valid delayed by one cycle, giving a fixed latency of 2 cycles from sampled in_valid to out_valid.
REQ-016 With s1_valid=0, acc and out_bit SHALL hold and out_valid SHALL be 0; input gaps do not disturb the residue.
REQ-017 The block SHALL have no backpressure: one result per accepted input, with full throughput on back-to-back in_valid.
REQ-018 clear=1 SHALL, at the next edge, set acc to its reset value, out_bit=0, out_valid=0, s1_valid=0, and cnt=0.
REQ-019 clear=1 together with in_valid=1 SHALL give priority to clear; that input is discarded.
REQ-020 The long-run density of out_bit SHALL equal the mean density of in_bits over NUM_IN, with error < 1/N after N outputs.

Reset
REQ-021 Assertion of rst_n=0 SHALL immediately force cnt=0, s1_valid=0, out_valid=0, out_bit=0, and acc=ACC_INIT, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight data; the first valid input after deassertion SHALL produce out_valid 2 cycles later.

Configuration
REQ-023 Macro PCNT_USADD_BIAS_EN defined SHALL make ACC_INIT = floor(NUM_IN/2), giving round-to-nearest output.
REQ-024 Macro PCNT_USADD_BIAS_EN undefined SHALL make ACC_INIT = 0, giving truncating output.
REQ-025 ACC_INIT SHALL apply to both reset and clear.

Structure
REQ-026 Shared package pcnt_pkg SHALL hold the clog2-based width function and the ACC_INIT computation.
REQ-027 Sub-module pcnt_tree, a parametrised NUM_IN combinational popcount built as a full-adder/carry-save tree, SHALL implement the stage-1 count.
REQ-028 pcnt_usadd SHALL contain only the pipeline registers, the accumulator, and the control logic.

Verification (NUM_IN=15, BIAS off unless stated)
REQ-029 Reset check: hold rst_n=0 with random inputs -> cnt=0, acc=0, out_valid=0, out_bit=0; asynchronous release mid-cycle is clean.
REQ-030 All-ones check: in_bits=0x7FFF valid for 4 cycles -> out_valid cycles 2..5, out_bit=1,1,1,1, acc=0 throughout.
REQ-031 Popcount-7 check: in_bits=0x007F valid 5 cycles -> acc=7,14,6,13,5 and out_bit=0,0,1,0,1.
REQ-032 Gap check: popcount 5, then 3 idle cycles, then popcount 10 -> acc=5 held during the gap, then 0 with out_bit=1; out_valid low during the gap.
REQ-033 Clear check: acc=13, then clear=1 with in_valid=1 and in_bits=0x7FFF -> next cycle acc=0, out_valid=0, and that input produces no output.
REQ-034 Bias check: with PCNT_USADD_BIAS_EN, reset -> acc=7; then popcount 8 -> out_bit=1, acc=0; then popcount 7 -> out_bit=0, acc=7.

Source files
------------

// File: rtl/pcnt_pkg.sv
// Shared width math and accumulator start value for the unary scaled adder.
// PCNT_USADD_BIAS_EN selects a half-scale start value (round-to-nearest) instead of zero (truncate).
package pcnt_pkg;

`ifdef PCNT_USADD_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    function automatic int pcnt_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int pcnt_acc_init(input int num_in);
        return BIAS_EN ? (num_in / 2) : 0;
    endfunction

endpackage

// File: rtl/pcnt_tree.sv
// Combinational popcount of N bits as a recursive full-adder tree.
// Zero latency, no flow control.
module pcnt_tree
    import pcnt_pkg::*;
#(
    parameter  int N = 15,
    localparam int W = pcnt_clog2(N + 1)
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] cnt_o
);

    if (N == 2) begin : g_ha
        assign cnt_o = {bits_i[0] & bits_i[1], bits_i[0] ^ bits_i[1]};
    end else if (N == 3) begin : g_fa
        assign cnt_o = {(bits_i[0] & bits_i[1]) | (bits_i[2] & (bits_i[0] ^ bits_i[1])),
                        ^bits_i};
    end else begin : g_split
        localparam int NL = N / 2;
        localparam int NR = N - NL;
        localparam int WL = pcnt_clog2(NL + 1);
        localparam int WR = pcnt_clog2(NR + 1);

        logic [WL-1:0] cnt_l;
        logic [WR-1:0] cnt_r;
        logic [W-1:0]  op_a;
        logic [W-1:0]  op_b;
        logic          carry;

        pcnt_tree #(.N(NL)) u_lo (.bits_i(bits_i[NL-1:0]), .cnt_o(cnt_l));
        pcnt_tree #(.N(NR)) u_hi (.bits_i(bits_i[N-1:NL]), .cnt_o(cnt_r));

        // Ripple of full adders; the halves sum to N, so the top carry is always zero.
        always_comb begin
            op_a  = W'(cnt_l);
            op_b  = W'(cnt_r);
            carry = 1'b0;
            cnt_o = '0;
            for (int i = 0; i < W; i++) begin
                cnt_o[i] = op_a[i] ^ op_b[i] ^ carry;
                carry    = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
            end
        end
    end

endmodule

// File: rtl/pcnt_usadd.sv
// Unary-stream scaled adder: popcount stage then modulo-NUM_IN accumulator emitting sum/NUM_IN bits.
// Two-cycle latency, full throughput, no backpressure; PCNT_USADD_BIAS_EN sets a half-scale start residue.
module pcnt_usadd
    import pcnt_pkg::*;
#(
    parameter  int NUM_IN = 15,
    localparam int CNTW   = pcnt_clog2(NUM_IN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [NUM_IN-1:0] in_bits,
    input  logic              clear,
    output logic              out_valid,
    output logic              out_bit,
    output logic [CNTW-1:0]   cnt,
    output logic [CNTW-1:0]   acc
);

    localparam logic [CNTW-1:0] ACC_INIT = CNTW'(pcnt_acc_init(NUM_IN));
    localparam logic [CNTW:0]   MODULUS  = (CNTW + 1)'(NUM_IN);

    logic [CNTW-1:0] tree_cnt;
    logic [CNTW:0]   sum;

    logic            s1_vld_q,  s1_vld_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;
    logic            out_vld_q, out_vld_d;
    logic            out_bit_q, out_bit_d;
    logic [CNTW-1:0] acc_q,     acc_d;

    pcnt_tree #(.N(NUM_IN)) u_tree (
        .bits_i (in_bits),
        .cnt_o  (tree_cnt)
    );

    always_comb begin
        s1_vld_d  = 1'b0;
        cnt_d     = cnt_q;
        out_vld_d = 1'b0;
        out_bit_d = out_bit_q;
        acc_d     = acc_q;
        sum       = {1'b0, acc_q} + {1'b0, cnt_q};

        // Clear flushes both stages and drops any input sampled alongside it.
        if (clear) begin
            cnt_d     = '0;
            out_bit_d = 1'b0;
            acc_d     = ACC_INIT;
        end else begin
            if (in_valid) begin
                s1_vld_d = 1'b1;
                cnt_d    = tree_cnt;
            end
            if (s1_vld_q) begin
                out_vld_d = 1'b1;
                if (sum >= MODULUS) begin
                    out_bit_d = 1'b1;
                    acc_d     = CNTW'(sum - MODULUS);
                end else begin
                    out_bit_d = 1'b0;
                    acc_d     = sum[CNTW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_bit_q <= 1'b0;
            acc_q     <= ACC_INIT;
        end else begin
            s1_vld_q  <= s1_vld_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            out_bit_q <= out_bit_d;
            acc_q     <= acc_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_bit   = out_bit_q;
    assign cnt       = cnt_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_pcnt_usadd.sv
// Bench for pcnt_usadd (NUM_IN=15): reset, directed vector table, randomized run against an arithmetic model.
module tb_pcnt_usadd;

    localparam int N = 15;
    localparam int W = 4;
`ifdef PCNT_USADD_BIAS_EN
    localparam int AI = N / 2;
`else
    localparam int AI = 0;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic         clear    = 1'b0;
    logic [N-1:0] in_bits  = '0;
    logic         out_valid;
    logic         out_bit;
    logic [W-1:0] cnt;
    logic [W-1:0] acc;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pcnt_usadd #(.NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .clear     (clear),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .cnt       (cnt),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          v;
        bit          c;
        logic [14:0] b;
        bit          ov;
        bit          ob;
        int          acc;
        int          cnt;
    } vec_t;

    typedef struct {
        int due;
        bit ob;
        int acc;
    } exp_t;

    vec_t tbl[26];
    int   tbl_n;
    exp_t q[$];
    int   run_acc;
    int   vis_acc;
    int   exp_cnt;
    bit   vis_ob;

    function automatic logic [31:0] pack(input bit ov, input bit ob, input int a, input int c);
        return {22'b0, ov, ob, a[3:0], c[3:0]};
    endfunction

    function automatic logic [31:0] obs();
        return {22'b0, out_valid, out_bit, acc, cnt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got {ov,ob,acc,cnt}=%b required %b", name, cyc, act[9:0], exp[9:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        run_acc = AI;
        vis_acc = AI;
        vis_ob  = 1'b0;
        exp_cnt = 0;
    endtask

    // Running residue: each accepted count adds to it, every full NUM_IN emits a one.
    task automatic model_accept(input bit v, input bit c, input logic [N-1:0] b);
        int   p;
        int   s;
        exp_t e;
        if (c) begin
            model_reset();
        end else if (v) begin
            p     = $countones(b);
            s     = run_acc + p;
            e.due = cyc + 2;
            e.ob  = (s / N) != 0;
            e.acc = s % N;
            q.push_back(e);
            run_acc = e.acc;
            exp_cnt = p;
        end
    endtask

    task automatic model_check();
        bit eov;
        eov = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            eov     = 1'b1;
            vis_ob  = q[0].ob;
            vis_acc = q[0].acc;
            void'(q.pop_front());
        end
        chk("rand", obs(), pack(eov, vis_ob, vis_acc, exp_cnt));
    endtask

    initial begin
`ifdef PCNT_USADD_BIAS_EN
        tbl_n  = 4;
        tbl[0] = '{1, 0, 15'h00FF, 0, 0, 7, 0};
        tbl[1] = '{1, 0, 15'h007F, 0, 0, 7, 8};
        tbl[2] = '{0, 0, 15'h0000, 1, 1, 0, 7};
        tbl[3] = '{0, 0, 15'h0000, 1, 0, 7, 7};
`else
        tbl_n   = 26;
        tbl[0]  = '{1, 0, 15'h7FFF, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 15'h7FFF, 0, 0, 0, 15};
        tbl[2]  = '{1, 0, 15'h7FFF, 1, 1, 0, 15};
        tbl[3]  = '{1, 0, 15'h7FFF, 1, 1, 0, 15};
        tbl[4]  = '{0, 0, 15'h0000, 1, 1, 0, 15};
        tbl[5]  = '{0, 0, 15'h0000, 1, 1, 0, 15};
        tbl[6]  = '{1, 0, 15'h007F, 0, 1, 0, 15};
        tbl[7]  = '{1, 0, 15'h007F, 0, 1, 0, 7};
        tbl[8]  = '{1, 0, 15'h007F, 1, 0, 7, 7};
        tbl[9]  = '{1, 0, 15'h007F, 1, 0, 14, 7};
        tbl[10] = '{1, 0, 15'h007F, 1, 1, 6, 7};
        tbl[11] = '{0, 0, 15'h0000, 1, 0, 13, 7};
        tbl[12] = '{0, 0, 15'h0000, 1, 1, 5, 7};
        tbl[13] = '{0, 1, 15'h0000, 0, 1, 5, 7};
        tbl[14] = '{1, 0, 15'h001F, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 15'h0000, 0, 0, 0, 5};
        tbl[16] = '{0, 0, 15'h0000, 1, 0, 5, 5};
        tbl[17] = '{0, 0, 15'h0000, 0, 0, 5, 5};
        tbl[18] = '{1, 0, 15'h03FF, 0, 0, 5, 5};
        tbl[19] = '{0, 0, 15'h0000, 0, 0, 5, 10};
        tbl[20] = '{1, 0, 15'h007F, 1, 1, 0, 10};
        tbl[21] = '{1, 0, 15'h003F, 0, 1, 0, 7};
        tbl[22] = '{0, 0, 15'h0000, 1, 0, 7, 6};
        tbl[23] = '{1, 1, 15'h7FFF, 1, 0, 13, 6};
        tbl[24] = '{0, 0, 15'h0000, 0, 0, 0, 0};
        tbl[25] = '{0, 0, 15'h0000, 0, 0, 0, 0};
`endif

        // Reset held with random traffic on the inputs.
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            in_bits  = N'($urandom);
            tick();
            chk("reset_hold", obs(), pack(0, 0, AI, 0));
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl_n; i++) begin
            tick();
            chk($sformatf("vec%0d", i), obs(), pack(tbl[i].ov, tbl[i].ob, tbl[i].acc, tbl[i].cnt));
            in_valid = tbl[i].v;
            clear    = tbl[i].c;
            in_bits  = tbl[i].b;
        end

        tick();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            model_check();
            in_valid = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 24) == 0);
            in_bits  = N'($urandom);
            if (i % 50 == 7) begin
                in_bits = '1;
            end
            model_accept(in_valid, clear, in_bits);
            if (i == 200) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("async_reset", obs(), pack(0, 0, AI, 0));
                model_reset();
                clear = 1'b0;
                tick();
                chk("reset_mid", obs(), pack(0, 0, AI, 0));
                in_valid = 1'b1;
                in_bits  = N'($urandom);
                @(negedge clk);
                rst_n = 1'b1;
                model_accept(1'b1, 1'b0, in_bits);
            end
            tick();
        end
        model_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
